// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - command queue, issue register and result capture in front of an 8-bit ALU
//
// Purpose:
//   Buffers ALU commands in a registered FIFO, drives the combinational ALU from a
//   registered issue stage and captures its output into a result register. Chained
//   commands take operand A from the accumulator (the last captured result).
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   i_cmd_valid / o_cmd_ready      command handshake
//   i_cmd_a, i_cmd_b, i_cmd_sel    command operands and ALU select
//   i_cmd_chain                    use accumulator instead of i_cmd_a
//   o_alu_a, o_alu_b, o_alu_sel    registered ALU inputs
//   i_alu_out, i_alu_carry         ALU result and carry
//   o_res_valid / i_res_ready      result handshake
//   o_res_data, o_res_carry        captured result and carry
//   o_busy                         any command queued, issuing or awaiting consumption
module alu_issue_ctrl #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [WIDTH-1:0] i_cmd_a,
  input  logic [WIDTH-1:0] i_cmd_b,
  input  logic [SEL_W-1:0] i_cmd_sel,
  input  logic             i_cmd_chain,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [SEL_W-1:0] o_alu_sel,
  input  logic [WIDTH-1:0] i_alu_out,
  input  logic             i_alu_carry,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_data,
  output logic             o_res_carry,
  output logic             o_busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // FIFO storage carries no reset: the pointers and count define what is valid.
  logic [WIDTH-1:0] r_fifo_a     [DEPTH];
  logic [WIDTH-1:0] r_fifo_b     [DEPTH];
  logic [SEL_W-1:0] r_fifo_sel   [DEPTH];
  logic             r_fifo_chain [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             r_iss_valid;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [SEL_W-1:0] r_alu_sel;

  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_carry;
  logic [WIDTH-1:0] r_acc;

  logic             w_push;
  logic             w_fifo_nempty;
  logic             w_advance;
  logic             w_iss_free;
  logic             w_hazard;
  logic             w_load;
  logic [WIDTH-1:0] w_head_a;
  logic [WIDTH-1:0] w_head_b;
  logic [SEL_W-1:0] w_head_sel;
  logic             w_head_chain;

  // Ready depends on occupancy only, so a full FIFO never accepts even while popping.
  assign o_cmd_ready   = (r_count != CNT_W'(DEPTH));
  assign w_push        = i_cmd_valid & o_cmd_ready;
  assign w_fifo_nempty = (r_count != '0);

  assign w_head_a      = r_fifo_a[r_rd_ptr];
  assign w_head_b      = r_fifo_b[r_rd_ptr];
  assign w_head_sel    = r_fifo_sel[r_rd_ptr];
  assign w_head_chain  = r_fifo_chain[r_rd_ptr];

  assign w_advance     = r_iss_valid & (~r_res_valid | i_res_ready);
  assign w_iss_free    = ~r_iss_valid | w_advance;
  // A chained head waits until its producer has left the issue stage, so the
  // accumulator it reads already holds that producer's result.
  assign w_hazard      = w_head_chain & r_iss_valid;
  assign w_load        = w_fifo_nempty & w_iss_free & ~w_hazard;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_a[r_wr_ptr]     <= i_cmd_a;
      r_fifo_b[r_wr_ptr]     <= i_cmd_b;
      r_fifo_sel[r_wr_ptr]   <= i_cmd_sel;
      r_fifo_chain[r_wr_ptr] <= i_cmd_chain;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_iss_valid <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_carry <= 1'b0;
      r_acc       <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      // ALU inputs only change on a load, so they hold steady while idle.
      if (w_load) begin
        r_iss_valid <= 1'b1;
        r_alu_a     <= w_head_chain ? r_acc : w_head_a;
        r_alu_b     <= w_head_b;
        r_alu_sel   <= w_head_sel;
      end else if (w_advance) begin
        r_iss_valid <= 1'b0;
      end

      if (w_advance) begin
        r_res_valid <= 1'b1;
        r_res_data  <= i_alu_out;
        r_res_carry <= i_alu_carry;
        r_acc       <= i_alu_out;
      end else if (r_res_valid && i_res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_sel   = r_alu_sel;
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_res_carry = r_res_carry;
  assign o_busy      = w_fifo_nempty | r_iss_valid | r_res_valid;

endmodule
